// File: rtl/alu_arbiter.sv
// Purpose : shares one combinational ALU between two requesters (round-robin) and returns a tagged response.
// Latency : request handshake in cycle N, rsp_valid from cycle N+2; at least 3 cycles per operation.
// Backpr. : rsp_ready low holds the response stable; both req readys stay low until the response is taken.
//
// Ports:
//    CLK, RST                      - clock (rising edge), asynchronous active-high reset
//    reqN_valid/ready/srca/srcb/ctrl - requester N operation channel (N = 0, 1)
//    reqN_lock                     - only with ALU_ARB_LOCK_EN: last owner keeps priority on ties
//    alu_srca/srcb/ctrl            - registered operands to the external ALU
//    alu_result/zero               - combinational ALU outputs
//    rsp_valid/ready/id/result/zero - tagged response channel
//
// Optional feature macro: ALU_ARB_LOCK_EN (adds req0_lock/req1_lock).
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_srca,
   input  logic [WIDTH-1:0] req0_srcb,
   input  logic [2:0]       req0_ctrl,
`ifdef ALU_ARB_LOCK_EN
   input  logic             req0_lock,
`endif

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_srca,
   input  logic [WIDTH-1:0] req1_srcb,
   input  logic [2:0]       req1_ctrl,
`ifdef ALU_ARB_LOCK_EN
   input  logic             req1_lock,
`endif

   output logic [WIDTH-1:0] alu_srca,
   output logic [WIDTH-1:0] alu_srcb,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic   last_grant;   // requester served most recently
   logic   owner_id;     // requester owning the operation in flight
   logic   grant;        // requester selected this IDLE cycle
   logic   prefer_last;  // last owner holds priority on a tie
   logic   op_load;      // request handshake this cycle
   logic   rsp_capture;  // ALU output sampled at the end of ISSUE
   logic   rsp_release;  // response handshake this cycle

   // ------------------------------------------------------------------
   // Arbitration: a lone valid requester always wins; on a tie the one
   // not served last wins, unless the last owner is holding its lock.
   // ------------------------------------------------------------------
   always_comb begin
`ifdef ALU_ARB_LOCK_EN
      prefer_last = last_grant ? req1_lock : req0_lock;
`else
      prefer_last = 1'b0;
`endif
      if (req0_valid && req1_valid) begin
         grant = prefer_last ? last_grant : ~last_grant;
      end else begin
         grant = req1_valid;
      end
   end

   always_comb begin
      req0_ready = (state == IDLE) && req0_valid && !grant;
      req1_ready = (state == IDLE) && req1_valid &&  grant;
   end

   // ------------------------------------------------------------------
   // FSM: next state and datapath enables
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      op_load     = 1'b0;
      rsp_capture = 1'b0;
      rsp_release = 1'b0;
      case (state)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               op_load   = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            // Operands have been on the ALU for a full cycle; take its output.
            rsp_capture = 1'b1;
            state_nxt   = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_release = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Operand registers: they feed the ALU directly and keep their last
   // value outside ISSUE, so the ALU inputs only change on an accept.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         alu_srca   <= '0;
         alu_srcb   <= '0;
         alu_ctrl   <= 3'b000;
         owner_id   <= 1'b0;
         last_grant <= 1'b1;   // requester 0 wins the first tie
      end else if (op_load) begin
         alu_srca   <= grant ? req1_srca : req0_srca;
         alu_srcb   <= grant ? req1_srcb : req0_srcb;
         alu_ctrl   <= grant ? req1_ctrl : req0_ctrl;
         owner_id   <= grant;
         last_grant <= grant;
      end
   end

   // ------------------------------------------------------------------
   // Response registers: loaded once at the end of ISSUE, held through
   // RESP until the consumer takes them.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else if (rsp_capture) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= owner_id;
         rsp_result <= alu_result;
         rsp_zero   <= alu_zero;
      end else if (rsp_release) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : directed self-checking bench for alu_arbiter with a behavioural ALU attached.
// Latency : steps one clock at a time; inputs change 1 time unit after the rising edge.
// Backpr. : exercises a stalled response consumer as well as an always-ready one.
module tb_alu_arbiter;

   localparam int WIDTH = 32;

   logic             CLK = 1'b0;
   logic             RST;
   logic             req0_valid, req0_ready;
   logic [WIDTH-1:0] req0_srca, req0_srcb;
   logic [2:0]       req0_ctrl;
   logic             req1_valid, req1_ready;
   logic [WIDTH-1:0] req1_srca, req1_srcb;
   logic [2:0]       req1_ctrl;
`ifdef ALU_ARB_LOCK_EN
   logic             req0_lock, req1_lock;
`endif
   logic [WIDTH-1:0] alu_srca, alu_srcb, alu_result;
   logic [2:0]       alu_ctrl;
   logic             alu_zero;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [WIDTH-1:0] rsp_result;

   int n_assert = 0;
   int n_fail   = 0;

   alu_arbiter #(.WIDTH(WIDTH)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_srca  (req0_srca),
      .req0_srcb  (req0_srcb),
      .req0_ctrl  (req0_ctrl),
`ifdef ALU_ARB_LOCK_EN
      .req0_lock  (req0_lock),
`endif
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_srca  (req1_srca),
      .req1_srcb  (req1_srcb),
      .req1_ctrl  (req1_ctrl),
`ifdef ALU_ARB_LOCK_EN
      .req1_lock  (req1_lock),
`endif
      .alu_srca   (alu_srca),
      .alu_srcb   (alu_srcb),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
   );

   always #5 CLK = ~CLK;

   // Behavioural ALU: AND, OR, ADD, SUB, SLT, MUL (low bits); other codes give 0.
   always_comb begin
      case (alu_ctrl)
         3'b000:  alu_result = alu_srca & alu_srcb;
         3'b001:  alu_result = alu_srca | alu_srcb;
         3'b010:  alu_result = alu_srca + alu_srcb;
         3'b100:  alu_result = alu_srca - alu_srcb;
         3'b101:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_srca) < $signed(alu_srcb))};
         3'b110:  alu_result = alu_srca * alu_srcb;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] c);
      req0_valid = v; req0_srca = a; req0_srcb = b; req0_ctrl = c;
   endtask

   task automatic set_req1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] c);
      req1_valid = v; req1_srca = a; req1_srcb = b; req1_ctrl = c;
   endtask

   initial begin
      RST = 1'b1;
      rsp_ready = 1'b0;
      set_req0(1'b0, '0, '0, 3'b000);
      set_req1(1'b0, '0, '0, 3'b000);
`ifdef ALU_ARB_LOCK_EN
      req0_lock = 1'b0;
      req1_lock = 1'b0;
`endif

      // ---- reset state; readys follow IDLE rules during reset ----
      #2;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rst_rsp_valid",  rsp_valid, 0);
      chk("rst_rsp_id",     rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_zero",   rsp_zero, 0);
      chk("rst_alu_srca",   alu_srca, 0);
      chk("rst_alu_srcb",   alu_srcb, 0);
      chk("rst_alu_ctrl",   alu_ctrl, 0);
      chk("rst_req0_ready", req0_ready, 1);
      chk("rst_req1_ready", req1_ready, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      step(); step();
      RST = 1'b0;
      step();

      // ---- tie after reset: req0 first (8+8), then req1 (0xF0 & 0x0F) ----
      set_req0(1'b1, 8, 8, 3'b010);
      set_req1(1'b1, 32'hF0, 32'h0F, 3'b000);
      rsp_ready = 1'b1;
      #1;
      chk("tie0_req0_ready", req0_ready, 1);
      chk("tie0_req1_ready", req1_ready, 0);
      step();                                   // ISSUE
      req0_valid = 1'b0;
      #1;
      chk("tie0_issue_srca", alu_srca, 8);
      chk("tie0_issue_ctrl", alu_ctrl, 3'b010);
      chk("tie0_issue_r1rdy", req1_ready, 0);
      chk("tie0_issue_vld", rsp_valid, 0);
      step();                                   // RESP
      chk("tie0_rsp_valid", rsp_valid, 1);
      chk("tie0_rsp_id",    rsp_id, 0);
      chk("tie0_rsp_result", rsp_result, 16);
      chk("tie0_rsp_zero",  rsp_zero, 0);
      chk("tie0_rsp_r1rdy", req1_ready, 0);
      step();                                   // IDLE
      chk("tie1_rsp_gone",  rsp_valid, 0);
      chk("tie1_req1_ready", req1_ready, 1);
      step();                                   // ISSUE
      req1_valid = 1'b0;
      step();                                   // RESP
      chk("tie1_rsp_valid", rsp_valid, 1);
      chk("tie1_rsp_id",    rsp_id, 1);
      chk("tie1_rsp_result", rsp_result, 0);
      chk("tie1_rsp_zero",  rsp_zero, 1);
      step();                                   // IDLE

      // ---- repeated tie: req1 was served last, so req0 wins ----
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("tie2_req0_ready", req0_ready, 1);
      chk("tie2_req1_ready", req1_ready, 0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      chk("tie2_rsp_id",     rsp_id, 0);
      chk("tie2_rsp_result", rsp_result, 16);
      step();

      // ---- single op 7-5 with rsp_ready high: 3-cycle round trip ----
      set_req0(1'b1, 7, 5, 3'b100);
      #1;
      chk("single_c0_ready", req0_ready, 1);
      step();                                   // cycle 1
      req0_valid = 1'b0;
      #1;
      chk("single_c1_vld",  rsp_valid, 0);
      chk("single_c1_srcb", alu_srcb, 5);
      chk("single_c1_ctrl", alu_ctrl, 3'b100);
      step();                                   // cycle 2
      chk("single_c2_vld",    rsp_valid, 1);
      chk("single_c2_id",     rsp_id, 0);
      chk("single_c2_result", rsp_result, 2);
      chk("single_c2_zero",   rsp_zero, 0);
      step();                                   // cycle 3
      chk("single_c3_vld", rsp_valid, 0);
      req1_valid = 1'b1;
      #1;
      chk("single_c3_idle", req1_ready, 1);
      req1_valid = 1'b0;
      step();

      // ---- backpressure: response held 5 cycles while both requesters wait ----
      rsp_ready = 1'b0;
      set_req0(1'b1, 20, 6, 3'b100);
      #1;
      chk("bp_accept", req0_ready, 1);
      step();                                   // ISSUE
      req0_valid = 1'b0;
      step();                                   // RESP
      set_req0(1'b1, 1, 2, 3'b010);
      set_req1(1'b1, 3, 4, 3'b111);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_hold_vld",    rsp_valid, 1);
         chk("bp_hold_id",     rsp_id, 0);
         chk("bp_hold_result", rsp_result, 14);
         chk("bp_hold_zero",   rsp_zero, 0);
         chk("bp_hold_r0rdy",  req0_ready, 0);
         chk("bp_hold_r1rdy",  req1_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_vld", rsp_valid, 1);
      step();                                   // IDLE, req0 served last
      chk("bp_idle_vld",   rsp_valid, 0);
      chk("bp_idle_r1rdy", req1_ready, 1);
      chk("bp_idle_r0rdy", req0_ready, 0);
      step();                                   // ISSUE with undefined code
      req1_valid = 1'b0;
      #1;
      chk("undef_alu_ctrl", alu_ctrl, 3'b111);
      chk("undef_alu_srca", alu_srca, 3);
      chk("undef_alu_srcb", alu_srcb, 4);
      step();                                   // RESP
      chk("undef_rsp_vld",    rsp_valid, 1);
      chk("undef_rsp_id",     rsp_id, 1);
      chk("undef_rsp_result", rsp_result, 0);
      chk("undef_rsp_zero",   rsp_zero, 1);
      step();                                   // IDLE, req0 still waiting
      chk("withdraw_ready", req0_ready, 1);
      req0_valid = 1'b0;                        // withdraw before the edge
      #1;
      chk("withdraw_noready", req0_ready, 0);
      step();
      chk("withdraw_no_rsp", rsp_valid, 0);
      chk("alu_hold_srca",   alu_srca, 3);

      // ---- reset during ISSUE ----
      set_req0(1'b1, 11, 22, 3'b001);
      step();
      req0_valid = 1'b0;
      #1;
      chk("rst_issue_pre_srca", alu_srca, 11);
      RST = 1'b1;
      #1;
      chk("rst_issue_vld",  rsp_valid, 0);
      chk("rst_issue_srca", alu_srca, 0);
      chk("rst_issue_ctrl", alu_ctrl, 0);
      step();
      RST = 1'b0;
      step();
      chk("rst_issue_dropped", rsp_valid, 0);

      // ---- reset during RESP ----
      rsp_ready = 1'b0;
      set_req1(1'b1, 5, 6, 3'b110);
      step();
      req1_valid = 1'b0;
      step();
      chk("rst_resp_pre_vld",    rsp_valid, 1);
      chk("rst_resp_pre_result", rsp_result, 30);
      RST = 1'b1;
      #1;
      chk("rst_resp_vld",    rsp_valid, 0);
      chk("rst_resp_result", rsp_result, 0);
      chk("rst_resp_id",     rsp_id, 0);
      chk("rst_resp_srcb",   alu_srcb, 0);
      step();
      RST = 1'b0;
      rsp_ready = 1'b1;
      step();

      // ---- after release requester 0 wins a tie again ----
      set_req0(1'b1, 100, 1, 3'b010);
      set_req1(1'b1, 1, 1, 3'b010);
      #1;
      chk("post_rst_r0rdy", req0_ready, 1);
      chk("post_rst_r1rdy", req1_ready, 0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      chk("post_rst_id",     rsp_id, 0);
      chk("post_rst_result", rsp_result, 101);
      step();

`ifdef ALU_ARB_LOCK_EN
      // ---- lock: req1 served, keeps the tie while locked ----
      set_req1(1'b1, 2, 3, 3'b101);
      step();
      req1_valid = 1'b0;
      step();
      chk("lock_slt_id",     rsp_id, 1);
      chk("lock_slt_result", rsp_result, 1);
      step();
      req1_lock = 1'b1;
      set_req0(1'b1, 4, 4, 3'b100);
      set_req1(1'b1, 7, 7, 3'b100);
      #1;
      chk("lock_on_r1rdy", req1_ready, 1);
      chk("lock_on_r0rdy", req0_ready, 0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      chk("lock_on_id",   rsp_id, 1);
      chk("lock_on_zero", rsp_zero, 1);
      step();
      req1_lock = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("lock_off_r0rdy", req0_ready, 1);
      chk("lock_off_r1rdy", req1_ready, 0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      chk("lock_off_id", rsp_id, 0);
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
